// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Merges pipeline writeback and a buffered long-latency source onto
//            the single register-file write port, with starvation stall.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_pipe_write,
  input  logic [4:0]               i_pipe_reg,
  input  logic [31:0]              i_pipe_data,
  input  logic                     i_aux_valid,
  input  logic [4:0]               i_aux_reg,
  input  logic [31:0]              i_aux_data,
  output logic                     o_aux_ready,
  input  logic [4:0]               i_query_reg,
  output logic                     o_query_hit,
  output logic                     o_stall,
  output logic [$clog2(DEPTH):0]   o_aux_count,
  output logic                     o_reg_write,
  output logic [4:0]               o_write_reg,
  output logic [31:0]              o_write_data
);

  localparam int                c_PW        = $clog2(DEPTH);
  localparam int                c_CW        = c_PW + 1;
  localparam logic [c_CW-1:0]   c_DEPTH_CNT = c_CW'(DEPTH);
  localparam logic [7:0]        c_LIMIT     = 8'(STARVE_LIMIT);

  logic [4:0]       r_mem_reg  [DEPTH];
  logic [31:0]      r_mem_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [c_PW-1:0]  r_wr_ptr;
  logic [c_PW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_count;
  logic [7:0]       r_starve;
  logic             r_stall;
  logic             r_init;
  logic             r_reg_write;
  logic [4:0]       r_write_reg;
  logic [31:0]      r_write_data;

  logic             w_pipe_eff;
  logic             w_push;
  logic             w_pop;
  logic [DEPTH-1:0] w_vld_nxt;
  logic [7:0]       w_starve_nxt;
  logic             w_query_hit;

  // r_init keeps the aux port closed until the first edge after reset release
  assign o_aux_ready = r_init && (r_count < c_DEPTH_CNT);
  assign w_pipe_eff  = i_pipe_write && (i_pipe_reg != 5'd0);
  assign w_push      = i_aux_valid && o_aux_ready && (i_aux_reg != 5'd0);
  assign w_pop       = !w_pipe_eff && (r_count != '0);

  always_comb begin
    w_vld_nxt = r_vld;
    if (w_pop)  w_vld_nxt[r_rd_ptr] = 1'b0;
    if (w_push) w_vld_nxt[r_wr_ptr] = 1'b1;
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (w_pop || (r_count == '0))
      w_starve_nxt = 8'd0;
    else if (w_pipe_eff && (r_starve != c_LIMIT))
      w_starve_nxt = r_starve + 8'd1;
  end

  always_comb begin
    w_query_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_mem_reg[i] == i_query_reg))
        w_query_hit = 1'b1;
    end
  end

  assign o_query_hit = w_query_hit && (i_query_reg != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_reg[i]  <= 5'd0;
        r_mem_data[i] <= 32'd0;
      end
      r_vld        <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_starve     <= 8'd0;
      r_stall      <= 1'b0;
      r_init       <= 1'b0;
      r_reg_write  <= 1'b0;
      r_write_reg  <= 5'd0;
      r_write_data <= 32'd0;
    end else begin
      r_init <= 1'b1;
      if (w_push) begin
        r_mem_reg[r_wr_ptr]  <= i_aux_reg;
        r_mem_data[r_wr_ptr] <= i_aux_data;
        r_wr_ptr             <= r_wr_ptr + 1'b1;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_vld    <= w_vld_nxt;
      r_count  <= r_count + c_CW'(w_push) - c_CW'(w_pop);
      r_starve <= w_starve_nxt;
      r_stall  <= (w_starve_nxt == c_LIMIT);

      // Primary always wins; the FIFO only drains into idle pipeline slots
      if (w_pipe_eff) begin
        r_reg_write  <= 1'b1;
        r_write_reg  <= i_pipe_reg;
        r_write_data <= i_pipe_data;
      end else if (w_pop) begin
        r_reg_write  <= 1'b1;
        r_write_reg  <= r_mem_reg[r_rd_ptr];
        r_write_data <= r_mem_data[r_rd_ptr];
      end else begin
        r_reg_write  <= 1'b0;
      end
    end
  end

  assign o_stall      = r_stall;
  assign o_aux_count  = r_count;
  assign o_reg_write  = r_reg_write;
  assign o_write_reg  = r_write_reg;
  assign o_write_data = r_write_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Directed self-checking bench for regfile_write_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_pipe_write;
  logic [4:0]  i_pipe_reg;
  logic [31:0] i_pipe_data;
  logic        i_aux_valid;
  logic [4:0]  i_aux_reg;
  logic [31:0] i_aux_data;
  logic        o_aux_ready;
  logic [4:0]  i_query_reg;
  logic        o_query_hit;
  logic        o_stall;
  logic [2:0]  o_aux_count;
  logic        o_reg_write;
  logic [4:0]  o_write_reg;
  logic [31:0] o_write_data;

  int n_cmp;
  int n_err;

  regfile_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(2)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_pipe_write (i_pipe_write),
    .i_pipe_reg   (i_pipe_reg),
    .i_pipe_data  (i_pipe_data),
    .i_aux_valid  (i_aux_valid),
    .i_aux_reg    (i_aux_reg),
    .i_aux_data   (i_aux_data),
    .o_aux_ready  (o_aux_ready),
    .i_query_reg  (i_query_reg),
    .o_query_hit  (o_query_hit),
    .o_stall      (o_stall),
    .o_aux_count  (o_aux_count),
    .o_reg_write  (o_reg_write),
    .o_write_reg  (o_write_reg),
    .o_write_data (o_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    i_pipe_write = 1'b0; i_pipe_reg = 5'd0; i_pipe_data = 32'd0;
    i_aux_valid  = 1'b0; i_aux_reg  = 5'd0; i_aux_data  = 32'd0;
    i_query_reg  = 5'd0;

    // Reset state
    #12;
    chk("rst_regwrite", 32'(o_reg_write), 32'd0);
    chk("rst_ready",    32'(o_aux_ready), 32'd0);
    chk("rst_count",    32'(o_aux_count), 32'd0);
    chk("rst_stall",    32'(o_stall),     32'd0);
    chk("rst_wreg",     32'(o_write_reg), 32'd0);
    chk("rst_wdata",    o_write_data,     32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_ready",    32'(o_aux_ready), 32'd1);
    chk("idle_regwrite", 32'(o_reg_write), 32'd0);

    // Write to r0 is no request
    i_pipe_write = 1'b1; i_pipe_reg = 5'd0; i_pipe_data = 32'hFFFF_FFFF;
    tick();
    chk("r0_regwrite", 32'(o_reg_write), 32'd0);
    chk("r0_wdata",    o_write_data,     32'd0);

    // Primary write, one cycle latency, one cycle wide
    i_pipe_reg = 5'd5; i_pipe_data = 32'h1234_5678;
    tick();
    chk("pipe_regwrite", 32'(o_reg_write), 32'd1);
    chk("pipe_wreg",     32'(o_write_reg), 32'd5);
    chk("pipe_wdata",    o_write_data,     32'h1234_5678);
    i_pipe_write = 1'b0;
    tick();
    chk("pipe_done",      32'(o_reg_write), 32'd0);
    chk("pipe_hold_wreg", 32'(o_write_reg), 32'd5);
    chk("pipe_hold_data", o_write_data,     32'h1234_5678);

    // Five pushes to regs 1..5 under continuous primary writes to r9
    i_pipe_write = 1'b1; i_pipe_reg = 5'd9; i_pipe_data = 32'h0000_0099;
    i_aux_valid  = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      i_aux_reg  = 5'(k);
      i_aux_data = 32'h0000_00A0 + 32'(k);
      chk("fill_ready", 32'(o_aux_ready), 32'd1);
      tick();
    end
    i_aux_reg = 5'd5; i_aux_data = 32'h0000_00A5;
    chk("full_ready",    32'(o_aux_ready), 32'd0);
    chk("full_count",    32'(o_aux_count), 32'd4);
    chk("full_regwrite", 32'(o_reg_write), 32'd1);
    chk("full_wreg",     32'(o_write_reg), 32'd9);
    i_query_reg = 5'd3; #1;
    chk("query3", 32'(o_query_hit), 32'd1);
    i_query_reg = 5'd7; #1;
    chk("query7", 32'(o_query_hit), 32'd0);
    i_query_reg = 5'd0; #1;
    chk("query0", 32'(o_query_hit), 32'd0);

    // Drain: 1 first; reg 5 gets accepted once a slot frees up
    i_pipe_write = 1'b0;
    tick();
    chk("drain1_wreg",  32'(o_write_reg), 32'd1);
    chk("drain1_wdata", o_write_data,     32'h0000_00A1);
    chk("drain1_ready", 32'(o_aux_ready), 32'd1);
    chk("drain1_count", 32'(o_aux_count), 32'd3);
    chk("drain1_stall", 32'(o_stall),     32'd0);
    tick();
    i_aux_valid = 1'b0;
    chk("drain2_wreg",  32'(o_write_reg), 32'd2);
    chk("drain2_count", 32'(o_aux_count), 32'd3);
    tick();
    chk("drain3_wreg",  32'(o_write_reg), 32'd3);
    tick();
    chk("drain4_wreg",  32'(o_write_reg), 32'd4);
    chk("drain4_wdata", o_write_data,     32'h0000_00A4);
    tick();
    chk("drain5_we",    32'(o_reg_write), 32'd1);
    chk("drain5_wreg",  32'(o_write_reg), 32'd5);
    chk("drain5_wdata", o_write_data,     32'h0000_00A5);
    tick();
    chk("drained_we",    32'(o_reg_write), 32'd0);
    chk("drained_count", 32'(o_aux_count), 32'd0);

    // Starvation with limit 2
    i_pipe_write = 1'b1; i_pipe_reg = 5'd10; i_pipe_data = 32'h0000_1010;
    i_aux_valid  = 1'b1; i_aux_reg  = 5'd7;  i_aux_data  = 32'h0000_0077;
    tick();
    i_aux_valid = 1'b0;
    chk("starve_q_count", 32'(o_aux_count), 32'd1);
    tick();
    chk("starve_b1_stall", 32'(o_stall), 32'd0);
    tick();
    chk("starve_b2_stall", 32'(o_stall),     32'd1);
    chk("starve_b2_wreg",  32'(o_write_reg), 32'd10);
    tick();
    chk("starve_hold_stall", 32'(o_stall),     32'd1);
    chk("starve_hold_count", 32'(o_aux_count), 32'd1);
    i_pipe_write = 1'b0;
    tick();
    chk("starve_pop_we",    32'(o_reg_write), 32'd1);
    chk("starve_pop_wreg",  32'(o_write_reg), 32'd7);
    chk("starve_pop_wdata", o_write_data,     32'h0000_0077);
    chk("starve_pop_stall", 32'(o_stall),     32'd0);
    chk("starve_pop_count", 32'(o_aux_count), 32'd0);
    tick();
    chk("starve_after_we", 32'(o_reg_write), 32'd0);

    // Aux write to r0 is discarded
    i_aux_valid = 1'b1; i_aux_reg = 5'd0; i_aux_data = 32'h0000_DEAD;
    tick();
    i_aux_valid = 1'b0;
    chk("zero_count", 32'(o_aux_count), 32'd0);
    tick();
    chk("zero_we",    32'(o_reg_write), 32'd0);
    chk("zero_wdata", o_write_data,     32'h0000_0077);

    // Mid-operation reset with three queued entries
    i_pipe_write = 1'b1; i_pipe_reg = 5'd11; i_pipe_data = 32'h0000_000B;
    i_aux_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_aux_reg  = 5'(12 + k);
      i_aux_data = 32'h0000_000C + 32'(k);
      tick();
    end
    i_aux_valid = 1'b0;
    chk("pre_rst_count", 32'(o_aux_count), 32'd3);
    chk("pre_rst_we",    32'(o_reg_write), 32'd1);
    #2;
    i_pipe_write = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_we",    32'(o_reg_write), 32'd0);
    chk("async_rst_count", 32'(o_aux_count), 32'd0);
    chk("async_rst_ready", 32'(o_aux_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    i_query_reg = 5'd12; #1;
    chk("post_rst_query", 32'(o_query_hit), 32'd0);
    tick();
    chk("post_rst_we",    32'(o_reg_write), 32'd0);
    chk("post_rst_ready", 32'(o_aux_ready), 32'd1);
    tick();
    chk("post_rst_we2",   32'(o_reg_write), 32'd0);

    // Aux latency: accepted at edge N, written at edge N+1 (visible in N+2)
    i_aux_valid = 1'b1; i_aux_reg = 5'd20; i_aux_data = 32'h0000_2020;
    tick();
    i_aux_valid = 1'b0;
    i_query_reg = 5'd20; #1;
    chk("lat_no_bypass", 32'(o_reg_write), 32'd0);
    chk("lat_count",     32'(o_aux_count), 32'd1);
    chk("lat_query",     32'(o_query_hit), 32'd1);
    tick();
    chk("lat_we",    32'(o_reg_write), 32'd1);
    chk("lat_wreg",  32'(o_write_reg), 32'd20);
    chk("lat_wdata", o_write_data,     32'h0000_2020);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Merges the two writeback producers of the MIPS32 core into the single register-file write port. Register-file writes come from the primary in-order pipeline writeback and from a secondary long-latency source (load completion, multiply/divide results) that uses a valid/ready handshake. Secondary writes are buffered in a small FIFO and drained in slots the pipeline leaves idle. A starvation counter forces a drain slot, and a query port lets issue logic detect registers with writes still pending.

## Interface
- DEPTH, 4: aux FIFO entries; power of two, at least 2.
- STARVE_LIMIT, 8: consecutive blocked cycles with a non-empty FIFO before Stall asserts; range 1–255.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; all state clears immediately on assertion.
- PipeWrite  in  1  primary write request; no ready signal, always accepted.
- PipeReg  in  5  primary destination register.
- PipeData  in  32  primary write data.
- AuxValid  in  1  secondary write offered.
- AuxReg  in  5  secondary destination register.
- AuxData  in  32  secondary write data.
- AuxReady  out  1  FIFO can accept an entry; transfer happens when AuxValid and AuxReady are both high at a rising edge.
- QueryReg  in  5  register looked up by issue logic.
- QueryHit  out  1  combinational; 1 when any valid FIFO entry targets QueryReg and QueryReg != 0.
- Stall  out  1  registered; asks the pipeline to drive PipeWrite=0 next cycle.
- AuxCount  out  clog2(DEPTH)+1  number of valid FIFO entries.
- RegWrite  out  1  registered write enable to the register file.
- WriteReg  out  5  registered write index.
- WriteData  out  32  registered write data.

## Operation
- Reset: RegWrite=0, WriteReg=0, WriteData=0, Stall=0, AuxCount=0, starve counter=0, FIFO empty.
  - AuxReady=0 while reset is low; AuxReady=1 from the first cycle after reset goes high.
- Primary is effective when PipeWrite=1 and PipeReg != 0. PipeWrite with PipeReg=0 counts as no request.
- Per-edge arbitration, with outputs registered:
  - Primary effective: output {1, PipeReg, PipeData}. The FIFO is not popped.
  - Else FIFO non-empty: output the head entry and pop it.
  - Else: RegWrite=0. WriteReg and WriteData hold their previous values.
- Push:
  - AuxReady = (AuxCount < DEPTH). It depends only on registered state; there is no combinational path from AuxValid.
  - An accepted entry with AuxReg=0 is discarded and not enqueued.
  - Push and pop in the same cycle: AuxCount is unchanged, FIFO order is preserved, and the pointers wrap modulo DEPTH.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and a primary write wins.
  - Clears on any pop, or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Stall:
  - Registered as (counter == STARVE_LIMIT).
  - In a Stall=1 cycle the pipeline drives PipeWrite=0, so the head is drained and the counter clears; Stall falls the cycle after the pop.
  - If PipeWrite is still effective while Stall=1, the primary wins, the counter holds and Stall stays high.
- Ordering: no WAW reordering is performed. Issue logic uses QueryHit to hold any pipeline instruction whose destination has a queued aux write.

## Timing
- Primary latency: request in cycle N appears on RegWrite/WriteReg/WriteData in cycle N+1.
- Aux latency: accepted at edge N, earliest output in cycle N+2 (no bypass around the FIFO).
- Throughput: one register-file write per cycle. With no primary traffic the FIFO drains one entry per cycle.
- Full FIFO: AuxReady drops in the cycle after the DEPTH-th push and rises in the cycle after the first pop.
- Mid-operation reset: queued entries are lost. RegWrite=0 is visible immediately, asynchronously.
- QueryHit reflects FIFO contents after the last edge. An entry in its pop cycle still hits; an entry being pushed this cycle does not.

## Test plan
- Reset then idle -> RegWrite=0, AuxReady=1, AuxCount=0, Stall=0; PipeWrite with PipeReg=0 -> RegWrite stays 0.
- PipeWrite, PipeReg=5, PipeData=0x12345678 at cycle 3 -> RegWrite=1, WriteReg=5, WriteData=0x12345678 in cycle 4 only.
- Five aux pushes to regs 1–5 (data 0xA1–0xA5) with PipeWrite=1 to reg 9 every cycle, DEPTH=4:
  - AuxReady=0 after the fourth push.
  - QueryReg=3 gives QueryHit=1.
  - After PipeWrite drops, writes occur to 1,2,3,4 on consecutive cycles, then 5.
- STARVE_LIMIT=2, one aux entry queued, continuous primary writes -> Stall=1 in the third blocked cycle; with PipeWrite=0 the next cycle, the aux entry is written and Stall returns to 0.
- Aux push with AuxReg=0, data 0xDEAD -> AuxCount stays 0 and no RegWrite results.
- Reset driven low with 3 entries queued and RegWrite=1 -> RegWrite=0 and AuxCount=0 immediately; no stale writes after release.
